ofm_requant_stream: RTL
=======================

Name: ofm_requant_stream

Overview:
- Output stage directly downstream of the c_psum channel-accumulation block.
- Captures the full partial-sum bank (MAC_N pixels x PE_N channels) when the accumulation reports finish.
- Applies optional ReLU, rounding right-shift and saturation to 4-bit activations.
- Packs the results and streams them out as AXI-Stream beats for DDR write-back.

Parameters:
- MAC_N, 14, output pixels per tile (one per MAC row).
- PE_N, 64, output channels per tile; must be a multiple of AXI_W/ACT_W.
- PSUM_W, 22, signed partial-sum width.
- ACT_W, 4, output activation width.
- AXI_W, 64, AXI-Stream data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- i_cpsum  in  MAC_N*PE_N*PSUM_W  psum bank; element (m,p) at bits [(m*PE_N+p)*PSUM_W +: PSUM_W], signed.
- i_finish  in  1  one-cycle pulse; i_cpsum is valid in this cycle.
- i_num_mac  in  4  valid pixels in this tile, 1..MAC_N; 0 means MAC_N.
- i_shift  in  5  requant right-shift amount, 0..21.
- i_relu_en  in  1  1 = ReLU with unsigned output, 0 = signed output.
- m_axis_tdata  out  AXI_W  packed activations.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the tile.
- o_busy  out  1  tile is captured or streaming.
- o_overrun  out  1  sticky flag: i_finish arrived while busy.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; capture bank, counters and shift/relu/num_mac registers cleared.
- FSM states:
  - IDLE: on i_finish, latch i_cpsum, i_shift, i_relu_en and i_num_mac (0 maps to MAC_N); o_busy=1 from the next cycle; go to LOAD.
  - LOAD: compute beat 0 into the output register; tvalid=1 from the next cycle; go to SEND.
  - SEND: on each tvalid&&tready, advance to the next beat and register it so there is no bubble under continuous ready. After the last beat is accepted: tvalid=0, o_busy=0, back to IDLE.
- Latency: i_finish in cycle 0 gives the first tvalid in cycle 2.
- Beat order:
  - BPP = PE_N*ACT_W/AXI_W beats per pixel (4 by default).
  - Beat index b = m*BPP + k, with pixel m from 0 to num_mac-1 and k from 0 to BPP-1.
  - Channel p = k*(AXI_W/ACT_W)+j goes at tdata[j*ACT_W +: ACT_W].
  - Total beats = num_mac*BPP (56 when num_mac=14).
  - tlast=1 only on the final beat.
- AXI rules:
  - tdata, tlast and tvalid stay stable while tvalid && !tready.
  - tvalid never drops before the beat is accepted.
- Quantization per element x (signed PSUM_W):
  - If relu and x<0, x=0.
  - If shift>0, add 1<<(shift-1) before an arithmetic shift right; compute in PSUM_W+1 bits so rounding cannot overflow.
  - relu=1: saturate to [0,15].
  - relu=0: saturate to [-8,7], two's complement.
  - Quantization is combinational over one beat's AXI_W/ACT_W elements, muxed from the capture bank.
- i_finish while busy (not IDLE):
  - Ignored; the current tile continues unaffected.
  - o_overrun is set and holds until reset.
- Reset asserted mid-stream: tvalid drops asynchronously and the tile is discarded.
- i_shift, i_relu_en and i_num_mac changes while busy have no effect until the next capture.

Optional Feature:
- Macro OFM_BIAS_EN.
- Defined:
  - Adds port i_bias, in, PE_N*16, signed per-channel bias; channel p at bits [p*16 +: 16].
  - i_bias is latched with i_cpsum on i_finish.
  - It is sign-extended and added to x before ReLU, in PSUM_W+1 bits with saturation to the PSUM_W+1 range.
- Undefined: i_bias port is absent; no adder is built; behaviour exactly as above.

Test Plan:
- All psums=37, shift=2, relu=1, num_mac=14, tready=1 → 56 consecutive beats, every nibble 9 (37+2=39, >>2=9), tdata=0x9999999999999999, tlast on beat 56, first tvalid 2 cycles after i_finish.
- psum(m,p)=-100, relu=0, shift=0 → all nibbles 0x8 (saturated -8). Same input with relu=1 → all nibbles 0.
- num_mac=3, distinct psum per channel (value=p, shift=0, relu=1) → 12 beats; beat 0 nibbles 0..15 with saturation above 15; tlast on beat 12.
- tready random 50% → tdata/tlast stable whenever tvalid&&!tready; beat count and contents match the reference model.
- i_finish pulsed during beat 10 → stream unchanged, o_overrun=1 and stays 1; rst low at beat 20 → tvalid=0 and o_busy=0 immediately, next i_finish starts a fresh tile.
- OFM_BIAS_EN defined, psum=0, bias(p)=-p*4, relu=1, shift=2 → channel 0 nibble 0, all other channels 0 (negative clipped); bias(p)=+28 → nibble 7.

Source files
------------

// File: rtl/ofm_requant_stream.sv
// Output stage after c_psum: captures the psum bank on finish, requantises to ACT_W
// activations and streams them as AXI-Stream beats. Optional per-channel bias: OFM_BIAS_EN.
module ofm_requant_stream #(
    parameter int MAC_N  = 14,
    parameter int PE_N   = 64,
    parameter int PSUM_W = 22,
    parameter int ACT_W  = 4,
    parameter int AXI_W  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAC_N*PE_N*PSUM_W-1:0]  i_cpsum,
    input  logic                          i_finish,
    input  logic [3:0]                    i_num_mac,
    input  logic [4:0]                    i_shift,
    input  logic                          i_relu_en,
`ifdef OFM_BIAS_EN
    input  logic [PE_N*16-1:0]            i_bias,
`endif
    output logic [AXI_W-1:0]              m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          o_busy,
    output logic                          o_overrun
);

    localparam int EPB = AXI_W / ACT_W;
    localparam int BPP = PE_N / EPB;
    localparam int M_W = (MAC_N > 1) ? $clog2(MAC_N) : 1;
    localparam int K_W = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int C_W = (PE_N > 1) ? $clog2(PE_N) : 1;
    localparam int W   = PSUM_W + 2;

    localparam logic signed [W-1:0] U_MAX = W'((1 << ACT_W) - 1);
    localparam logic signed [W-1:0] S_MAX = W'((1 << (ACT_W - 1)) - 1);
    localparam logic signed [W-1:0] S_MIN = W'(-(1 << (ACT_W - 1)));
`ifdef OFM_BIAS_EN
    localparam logic signed [W-1:0] X_MAX = W'((1 << PSUM_W) - 1);
    localparam logic signed [W-1:0] X_MIN = W'(-(1 << PSUM_W));
`endif
    localparam logic [K_W-1:0] K_LAST = K_W'(BPP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    state_t state_q, state_d;

    logic signed [PSUM_W-1:0] bank_q [MAC_N][PE_N];
`ifdef OFM_BIAS_EN
    logic signed [15:0]       bias_q [PE_N];
`endif
    logic [4:0]        shift_q;
    logic              relu_q;
    logic [M_W-1:0]    last_m_q, last_m_d;
    logic [M_W-1:0]    cur_m_q, sel_m;
    logic [K_W-1:0]    cur_k_q, sel_k;
    logic [AXI_W-1:0]  tdata_q, beat_data;
    logic              tvalid_q, tlast_q, overrun_q;
    logic              load_beat, accept, cur_last, sel_last;
    logic signed [W-1:0] elem [EPB];

    function automatic logic [ACT_W-1:0] requant(input logic signed [W-1:0] x,
                                                 input logic [4:0]          sh,
                                                 input logic                relu);
        logic signed [W-1:0] v;
        v = x;
        if (relu && v < 0)
            v = '0;
        // W = PSUM_W+2 leaves headroom for the rounding add even after a saturated bias sum
        if (sh != 5'd0)
            v = (v + (W'(1) << (sh - 5'd1))) >>> sh;
        if (relu) begin
            if (v > U_MAX)
                v = U_MAX;
        end else if (v > S_MAX) begin
            v = S_MAX;
        end else if (v < S_MIN) begin
            v = S_MIN;
        end
        return v[ACT_W-1:0];
    endfunction

    always_comb begin
        if (i_num_mac == 4'd0 || 32'(i_num_mac) > MAC_N)
            last_m_d = M_W'(MAC_N - 1);
        else
            last_m_d = M_W'(32'(i_num_mac) - 1);
    end

    assign accept   = tvalid_q && m_axis_tready;
    assign cur_last = (cur_m_q == last_m_q) && (cur_k_q == K_LAST);
    assign sel_last = (sel_m == last_m_q) && (sel_k == K_LAST);

    always_comb begin
        state_d   = state_q;
        sel_m     = cur_m_q;
        sel_k     = cur_k_q;
        load_beat = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_finish)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                sel_m     = '0;
                sel_k     = '0;
                load_beat = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (accept) begin
                    if (cur_last) begin
                        state_d = S_IDLE;
                    end else begin
                        load_beat = 1'b1;
                        if (cur_k_q == K_LAST) begin
                            sel_m = M_W'(cur_m_q + 1'b1);
                            sel_k = '0;
                        end else begin
                            sel_k = K_W'(cur_k_q + 1'b1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One beat's worth of elements muxed out of the bank, then requantised in parallel
    always_comb begin
        elem      = '{default: '0};
        beat_data = '0;
        for (int unsigned j = 0; j < EPB; j++) begin
            elem[j] = W'(bank_q[sel_m][C_W'(32'(sel_k) * EPB + j)]);
`ifdef OFM_BIAS_EN
            elem[j] = elem[j] + W'(bias_q[C_W'(32'(sel_k) * EPB + j)]);
            if (elem[j] > X_MAX)
                elem[j] = X_MAX;
            else if (elem[j] < X_MIN)
                elem[j] = X_MIN;
`endif
            beat_data[j*ACT_W +: ACT_W] = requant(elem[j], shift_q, relu_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bank_q    <= '{default: '0};
`ifdef OFM_BIAS_EN
            bias_q    <= '{default: '0};
`endif
            shift_q   <= '0;
            relu_q    <= 1'b0;
            last_m_q  <= '0;
            cur_m_q   <= '0;
            cur_k_q   <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && i_finish) begin
                for (int unsigned m = 0; m < MAC_N; m++)
                    for (int unsigned p = 0; p < PE_N; p++)
                        bank_q[m][p] <= i_cpsum[(m*PE_N + p)*PSUM_W +: PSUM_W];
`ifdef OFM_BIAS_EN
                for (int unsigned p = 0; p < PE_N; p++)
                    bias_q[p] <= i_bias[p*16 +: 16];
`endif
                shift_q  <= i_shift;
                relu_q   <= i_relu_en;
                last_m_q <= last_m_d;
            end
            if (state_q != S_IDLE && i_finish)
                overrun_q <= 1'b1;
            if (load_beat) begin
                tdata_q  <= beat_data;
                tlast_q  <= sel_last;
                cur_m_q  <= sel_m;
                cur_k_q  <= sel_k;
                tvalid_q <= 1'b1;
            end else if (state_q == S_SEND && accept) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_overrun     = overrun_q;

endmodule
